icache_fetch_controller: RTL and testbench

- Instruction-fetch front end that streams instruction words from memory over an AXI4 read channel (AR + R) using INCR bursts.
- Each returned word is pushed, tagged with its PC, into the downstream instruction FIFO.
- Handles FIFO back-pressure via stop_fetch and control-flow redirects via jump/jump_addr. On a redirect it drains any in-flight burst and restarts fetching at the target.

---
 rtl/icache_fetch_controller.sv | 174 +++++++++++++++++
 tb/tb_icache_fetch_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_controller.sv
// Instruction-fetch front end: streams words over AXI4 INCR read bursts into the
// instruction FIFO, with back-pressure (stop_fetch) and redirect (jump) handling.
module icache_fetch_controller #(
    parameter int unsigned BURST_LEN = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [31:0] rdata,
    input  logic        arready,
    input  logic        jump,
    output logic        jump_accept,
    input  logic [31:0] jump_addr,
    input  logic        stop_fetch,
    output logic        write_fifo,
    output logic        rready,
    output logic [31:0] araddr,
    output logic        arvalid,
    output logic [1:0]  arburst,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    output logic [63:0] fetch_instr_pc
);

    localparam int unsigned IDX_W   = $clog2(BURST_LEN);
    localparam logic [7:0]  LEN_MAX = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] beat_pc_q, beat_pc_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        arvalid_q, arvalid_d;
    logic        write_fifo_q, write_fifo_d;
    logic [63:0] fetch_q, fetch_d;
    logic        jump_pend_q, jump_pend_d;
    logic [31:0] jump_tgt_q, jump_tgt_d;
    logic        jump_accept_q, jump_accept_d;
    logic        rready_s;
    logic        clear_pend_s;

    // Next-state, datapath and handshake logic for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        beat_pc_d     = beat_pc_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        write_fifo_d  = 1'b0;
        fetch_d       = fetch_q;
        jump_accept_d = jump;
        rready_s      = 1'b0;
        clear_pend_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (jump_pend_q) begin
                    pc_d         = jump_tgt_q;
                    clear_pend_s = 1'b1;
                end else if (!stop_fetch) begin
                    // Trim the burst so it ends exactly on the next burst boundary.
                    araddr_d  = pc_q;
                    arlen_d   = LEN_MAX - 8'(pc_q[IDX_W+1:2]);
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    beat_pc_d = araddr_q;
                    state_d   = (jump_pend_q || jump) ? S_DRAIN : S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                rready_s = !stop_fetch;
                if (rvalid && rready_s) begin
                    write_fifo_d = 1'b1;
                    fetch_d      = {rdata, beat_pc_q};
                    beat_pc_d    = beat_pc_q + 32'd4;
                    if (rlast) begin
                        pc_d    = beat_pc_q + 32'd4;
                        state_d = S_IDLE;
                    end else if (jump) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (jump) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DRAIN: begin
                rready_s = 1'b1;
                if (rvalid && rlast) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new redirect always wins over one still waiting to be applied.
        if (jump) begin
            jump_pend_d = 1'b1;
            jump_tgt_d  = jump_addr & 32'hFFFF_FFFC;
        end else if (clear_pend_s) begin
            jump_pend_d = 1'b0;
            jump_tgt_d  = jump_tgt_q;
        end else begin
            jump_pend_d = jump_pend_q;
            jump_tgt_d  = jump_tgt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            beat_pc_q     <= RESET_PC;
            araddr_q      <= RESET_PC;
            arlen_q       <= LEN_MAX;
            arvalid_q     <= 1'b0;
            write_fifo_q  <= 1'b0;
            fetch_q       <= 64'd0;
            jump_pend_q   <= 1'b0;
            jump_tgt_q    <= 32'd0;
            jump_accept_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            beat_pc_q     <= beat_pc_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            write_fifo_q  <= write_fifo_d;
            fetch_q       <= fetch_d;
            jump_pend_q   <= jump_pend_d;
            jump_tgt_q    <= jump_tgt_d;
            jump_accept_q <= jump_accept_d;
        end
    end

    assign rready         = rready_s;
    assign araddr         = araddr_q;
    assign arlen          = arlen_q;
    assign arvalid        = arvalid_q;
    assign arburst        = 2'b01;
    assign arsize         = 3'b010;
    assign write_fifo     = write_fifo_q;
    assign fetch_instr_pc = fetch_q;
    assign jump_accept    = jump_accept_q;

endmodule

// File: tb/tb_icache_fetch_controller.sv
// Randomized bench: an AXI read-slave model feeds the fetch controller while an
// abstract instruction-stream model checks every FIFO push and AR request.
module tb_icache_fetch_controller;

    localparam int unsigned LEN      = 8;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          NCYC     = 3300;
    localparam int          RST_CYC  = 2500;
    localparam int          QUIET_LO = 300;
    localparam int          QUIET_HI = 3000;

    logic        clk = 1'b0;
    logic        rst_n, rvalid, rlast, arready, jump, stop_fetch;
    logic [31:0] rdata, jump_addr;
    logic        jump_accept, write_fifo, rready, arvalid;
    logic [31:0] araddr;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [63:0] fetch_instr_pc;

    icache_fetch_controller #(.BURST_LEN(LEN), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .rvalid(rvalid), .rlast(rlast), .rdata(rdata),
        .arready(arready), .jump(jump), .jump_accept(jump_accept),
        .jump_addr(jump_addr), .stop_fetch(stop_fetch), .write_fifo(write_fifo),
        .rready(rready), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arsize(arsize), .arlen(arlen), .fetch_instr_pc(fetch_instr_pc)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          sl_left = 0;
    logic [31:0] sl_addr = 32'd0;
    logic [31:0] exp_pc = RST_PC;
    logic [63:0] last_fetch = 64'd0;
    logic        first_ar = 1'b1;
    logic        rst_done = 1'b0;
    int          live_writes = 0;
    int          all_writes = 0;
    // Values seen just before the upcoming rising edge.
    logic        r_hs = 1'b0, ar_hs = 1'b0, p_stop = 1'b0, p_jump = 1'b0, p_rst = 1'b0;
    logic        p_arv = 1'b0, p_ard = 1'b0;
    logic [31:0] p_jaddr = 32'd0, p_araddr = 32'd0;
    logic [7:0]  p_arlen = 8'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_write_fifo", 64'(write_fifo), 64'd0);
        chk("rst_jump_accept", 64'(jump_accept), 64'd0);
        chk("rst_fetch", fetch_instr_pc, 64'd0);
        chk("rst_araddr", 64'(araddr), 64'(RST_PC));
        chk("rst_arlen", 64'(arlen), 64'(LEN - 1));
    endtask

    task automatic drive_inputs(input int cyc);
        logic quiet;
        quiet = (cyc < QUIET_LO) || (cyc >= QUIET_HI);
        if (!rst_done && cyc >= RST_CYC && sl_left > 1) begin
            rst_n    = 1'b1;
            rst_done = 1'b1;
        end else begin
            rst_n = 1'b0;
        end
        stop_fetch = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
        jump       = (!quiet && !rst_n) ? ($urandom_range(0, 29) == 0) : 1'b0;
        case ($urandom_range(0, 3))
            0:       jump_addr = $urandom;
            1:       jump_addr = 32'h0000_0100 + 32'($urandom_range(0, 63));
            2:       jump_addr = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            default: jump_addr = 32'h0000_010C;
        endcase
        arready = (sl_left == 0) ? (quiet ? 1'b1 : ($urandom_range(0, 2) != 0)) : 1'b0;
        if (sl_left > 0) begin
            if (!(rvalid && !r_hs)) begin
                rvalid = quiet ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
        end else begin
            rvalid = 1'b0;
        end
        rdata = mem_word(sl_addr);
        rlast = (sl_left == 1);
    endtask

    task automatic evaluate(input int cyc);
        longint unsigned a, bnd;
        if (p_rst) begin
            check_reset_outputs();
            exp_pc     = RST_PC;
            sl_left    = 0;
            last_fetch = 64'd0;
            first_ar   = 1'b1;
            return;
        end
        if (ar_hs) begin
            a   = longint'(p_araddr);
            bnd = (a / (LEN * 4) + 1) * (LEN * 4);
            chk("arlen_rule", 64'(p_arlen), (bnd - a) / 4 - 1);
            chk("araddr_align", 64'(p_araddr[1:0]), 64'd0);
            chk("arburst", 64'(arburst), 64'd1);
            chk("arsize", 64'(arsize), 64'd2);
            if (first_ar) begin
                chk("first_ar_addr", 64'(p_araddr), 64'(RST_PC));
                first_ar = 1'b0;
            end
            sl_left = int'(p_arlen) + 1;
            sl_addr = p_araddr;
        end
        if (r_hs) begin
            sl_addr = sl_addr + 32'd4;
            sl_left--;
        end
        if (write_fifo) begin
            chk("write_has_beat", 64'(r_hs), 64'd1);
            chk("write_not_stalled", 64'(p_stop), 64'd0);
            chk("fetch_pc", 64'(fetch_instr_pc[31:0]), 64'(exp_pc));
            chk("fetch_instr", 64'(fetch_instr_pc[63:32]), 64'(mem_word(exp_pc)));
            exp_pc     = exp_pc + 32'd4;
            last_fetch = fetch_instr_pc;
            all_writes++;
            if (cyc >= QUIET_HI) live_writes++;
        end else begin
            chk("fetch_hold", fetch_instr_pc, last_fetch);
        end
        chk("jump_accept", 64'(jump_accept), 64'(p_jump));
        if (p_jump) exp_pc = p_jaddr & 32'hFFFF_FFFC;
        if (p_arv && !p_ard) begin
            chk("arvalid_hold", 64'(arvalid), 64'd1);
            chk("araddr_hold", 64'(araddr), 64'(p_araddr));
            chk("arlen_hold", 64'(arlen), 64'(p_arlen));
        end
        if (!p_arv && arvalid) chk("issue_not_stalled", 64'(p_stop), 64'd0);
        if (arvalid) chk("single_outstanding", 64'(sl_left), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; arready = 1'b0;
        jump = 1'b0; jump_addr = 32'd0; stop_fetch = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive_inputs(cyc);
            #1;
            r_hs     = rvalid && rready;
            ar_hs    = arvalid && arready;
            p_stop   = stop_fetch;
            p_jump   = jump;
            p_jaddr  = jump_addr;
            p_arv    = arvalid;
            p_ard    = arready;
            p_araddr = araddr;
            p_arlen  = arlen;
            p_rst    = rst_n;
            @(negedge clk);
            evaluate(cyc);
        end
        chk("reset_pulse_applied", 64'(rst_done), 64'd1);
        chk("stream_progress", 64'(all_writes > 500), 64'd1);
        chk("quiet_liveness", 64'(live_writes >= 50), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
